// File: rtl/ex_alu_mc.sv
// rtl/ex_alu_mc.sv - Execute-stage ALU with registered single-cycle ops and an iterative shift-add MUL.
// Optional: define MUL_EARLY_EXIT_EN to finish MUL once the remaining multiplier bits are all zero.
module ex_alu_mc #(
    parameter int XLEN       = 32,
    parameter int MUL_CYCLES = 32
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            valid_i,
    input  logic [3:0]      ctrl_i,
    input  logic [XLEN-1:0] op1_i,
    input  logic [XLEN-1:0] op2_i,
    input  logic            flush_i,
    output logic            ready_o,
    output logic            stall_o,
    output logic [XLEN-1:0] result_o,
    output logic            zero_o,
    output logic            done_o
);
    localparam int SHW = $clog2(XLEN);
    localparam int CW  = $clog2(MUL_CYCLES + 1);

    localparam logic [3:0] OP_AND  = 4'd0;
    localparam logic [3:0] OP_XOR  = 4'd1;
    localparam logic [3:0] OP_SLL  = 4'd2;
    localparam logic [3:0] OP_ADD  = 4'd3;
    localparam logic [3:0] OP_SUB  = 4'd4;
    localparam logic [3:0] OP_MUL  = 4'd5;
    localparam logic [3:0] OP_ADDI = 4'd6;
    localparam logic [3:0] OP_SRAI = 4'd7;
    localparam logic [3:0] OP_LW   = 4'd8;
    localparam logic [3:0] OP_SW   = 4'd9;
    localparam logic [3:0] OP_BEQ  = 4'd10;

    typedef enum logic {IDLE, MUL_RUN} state_t;

    state_t          state_q, state_d;
    logic [XLEN-1:0] result_q, result_d;
    logic            zero_q, zero_d;
    logic            done_q, done_d;
    logic [XLEN-1:0] acc_q, acc_d;
    logic [XLEN-1:0] mcand_q, mcand_d;
    logic [XLEN-1:0] mplier_q, mplier_d;
    logic [CW-1:0]   cnt_q, cnt_d;

    logic            accept;
    logic [XLEN-1:0] alu_res;
    logic [XLEN-1:0] add_sum;
    logic [XLEN-1:0] mplier_nxt;
    logic            mul_last;
    logic [SHW-1:0]  shamt;

    // A flush in IDLE blocks acceptance, so flush wins over a simultaneous accept.
    assign ready_o  = (state_q == IDLE);
    assign accept   = valid_i && ready_o && !flush_i;
    assign stall_o  = (state_q == MUL_RUN) || (accept && (ctrl_i == OP_MUL));
    assign result_o = result_q;
    assign zero_o   = zero_q;
    assign done_o   = done_q;

    assign shamt      = op2_i[SHW-1:0];
    assign add_sum    = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
    assign mplier_nxt = mplier_q >> 1;
`ifdef MUL_EARLY_EXIT_EN
    assign mul_last   = (cnt_q == CW'(1)) || (mplier_nxt == '0);
`else
    assign mul_last   = (cnt_q == CW'(1));
`endif

    always_comb begin
        alu_res = '0;
        case (ctrl_i)
            OP_AND:                   alu_res = op1_i & op2_i;
            OP_XOR:                   alu_res = op1_i ^ op2_i;
            OP_SLL:                   alu_res = op1_i << shamt;
            OP_ADD, OP_ADDI,
            OP_LW, OP_SW:             alu_res = op1_i + op2_i;
            OP_SUB, OP_BEQ:           alu_res = op1_i - op2_i;
            OP_SRAI:                  alu_res = XLEN'($signed(op1_i) >>> shamt);
            default:                  alu_res = '0;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        result_d = result_q;
        zero_d   = zero_q;
        done_d   = 1'b0;
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        cnt_d    = cnt_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (ctrl_i == OP_MUL) begin
                        acc_d    = '0;
                        mcand_d  = op1_i;
                        mplier_d = op2_i;
                        cnt_d    = CW'(MUL_CYCLES);
                        state_d  = MUL_RUN;
                    end else begin
                        result_d = alu_res;
                        zero_d   = (alu_res == '0);
                        done_d   = 1'b1;
                    end
                end
            end
            MUL_RUN: begin
                if (flush_i) begin
                    state_d = IDLE;
                end else begin
                    acc_d    = add_sum;
                    mcand_d  = mcand_q << 1;
                    mplier_d = mplier_nxt;
                    cnt_d    = cnt_q - CW'(1);
                    if (mul_last) begin
                        result_d = add_sum;
                        zero_d   = (add_sum == '0);
                        done_d   = 1'b1;
                        state_d  = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            result_q <= '0;
            zero_q   <= 1'b1;
            done_q   <= 1'b0;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            result_q <= result_d;
            zero_q   <= zero_d;
            done_q   <= done_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            cnt_q    <= cnt_d;
        end
    end
endmodule

// File: tb/tb_ex_alu_mc.sv
// tb/tb_ex_alu_mc.sv - Directed self-checking bench for ex_alu_mc (honours MUL_EARLY_EXIT_EN).
module tb_ex_alu_mc;
    logic        clk = 1'b0;
    logic        rst;
    logic        valid;
    logic [3:0]  ctrl;
    logic [31:0] op1;
    logic [31:0] op2;
    logic        flush;
    logic        ready;
    logic        stall;
    logic [31:0] result;
    logic        zero;
    logic        done;

    int n_checks = 0;
    int n_fail   = 0;

    ex_alu_mc #(.XLEN(32), .MUL_CYCLES(32)) dut (
        .clk_i(clk), .rst_i(rst), .valid_i(valid), .ctrl_i(ctrl),
        .op1_i(op1), .op2_i(op2), .flush_i(flush),
        .ready_o(ready), .stall_o(stall), .result_o(result),
        .zero_o(zero), .done_o(done)
    );

    always #5 clk = ~clk;

`ifdef MUL_EARLY_EXIT_EN
    localparam int FLUSH_AT = 2;
`else
    localparam int FLUSH_AT = 10;
`endif

    task automatic drive(input logic v, input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
        valid = v; ctrl = c; op1 = a; op2 = b;
    endtask

    task automatic test_reset;
        rst = 1'b1; flush = 1'b0; drive(1'b0, 4'd0, 32'd0, 32'd0);
        repeat (2) @(negedge clk);
        n_checks++; if (result !== 32'd0) begin n_fail++; $display("FAIL reset_result got=%h exp=0", result); end
        n_checks++; if (zero !== 1'b1) begin n_fail++; $display("FAIL reset_zero got=%b exp=1", zero); end
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done got=%b exp=0", done); end
        n_checks++; if (ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready got=%b exp=1", ready); end
        rst = 1'b0;
        drive(1'b1, 4'd3, 32'd7, 32'd5);
        @(negedge clk);
        drive(1'b1, 4'd5, 32'd3, 32'h8000_0000);
        n_checks++; if (result !== 32'd12) begin n_fail++; $display("FAIL pre_reset_add got=%h exp=c", result); end
        @(negedge clk);
        drive(1'b0, 4'd0, 32'd0, 32'd0);
        repeat (3) @(negedge clk);
        n_checks++; if (stall !== 1'b1 || ready !== 1'b0) begin n_fail++; $display("FAIL mid_mul_busy stall=%b ready=%b exp 1/0", stall, ready); end
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        n_checks++; if (result !== 32'd0) begin n_fail++; $display("FAIL midmul_reset_result got=%h exp=0", result); end
        n_checks++; if (zero !== 1'b1) begin n_fail++; $display("FAIL midmul_reset_zero got=%b exp=1", zero); end
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL midmul_reset_done got=%b exp=0", done); end
        n_checks++; if (ready !== 1'b1) begin n_fail++; $display("FAIL midmul_reset_ready got=%b exp=1", ready); end
        n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL midmul_reset_stall got=%b exp=0", stall); end
        repeat (35) @(negedge clk);
        n_checks++; if (done !== 1'b0 || result !== 32'd0) begin n_fail++; $display("FAIL post_reset_quiet done=%b result=%h exp 0/0", done, result); end
    endtask

    task automatic test_back_to_back;
        logic [3:0]  c[10] = '{4'd3, 4'd4, 4'd7, 4'd2, 4'd0, 4'd1, 4'd6, 4'd8, 4'd9, 4'd13};
        logic [31:0] a[10] = '{32'd7, 32'd5, 32'h8000_0000, 32'd1, 32'hF0F0_F0F0,
                               32'hA5A5_A5A5, 32'hFFFF_FFFF, 32'h100, 32'h1000, 32'd5};
        logic [31:0] b[10] = '{32'd5, 32'd7, 32'd4, 32'd31, 32'hFF00_FF00,
                               32'hA5A5_A5A5, 32'd1, 32'h20, 32'h8, 32'd5};
        logic [31:0] e[10] = '{32'd12, 32'hFFFF_FFFE, 32'hF800_0000, 32'h8000_0000, 32'hF000_F000,
                               32'd0, 32'd0, 32'h120, 32'h1008, 32'd0};
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, c[i], a[i], b[i]);
            #1;
            n_checks++; if (stall !== 1'b0 || ready !== 1'b1) begin n_fail++; $display("FAIL b2b_handshake[%0d] stall=%b ready=%b exp 0/1", i, stall, ready); end
            @(negedge clk);
            n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL b2b_done[%0d] got=%b exp=1", i, done); end
            n_checks++; if (result !== e[i]) begin n_fail++; $display("FAIL b2b_result[%0d] got=%h exp=%h", i, result, e[i]); end
            n_checks++; if (zero !== (e[i] == 32'd0)) begin n_fail++; $display("FAIL b2b_zero[%0d] got=%b exp=%b", i, zero, (e[i] == 32'd0)); end
        end
        drive(1'b0, 4'd3, 32'd9, 32'd9);
        @(negedge clk);
        n_checks++; if (done !== 1'b0 || result !== 32'd0) begin n_fail++; $display("FAIL b2b_hold done=%b result=%h exp 0/0", done, result); end
    endtask

    task automatic test_beq;
        drive(1'b1, 4'd10, 32'h1234, 32'h1234);
        @(negedge clk);
        n_checks++; if (zero !== 1'b1 || result !== 32'd0) begin n_fail++; $display("FAIL beq_equal zero=%b result=%h exp 1/0", zero, result); end
        drive(1'b1, 4'd10, 32'd1, 32'd2);
        @(negedge clk);
        n_checks++; if (zero !== 1'b0 || result !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL beq_ne zero=%b result=%h exp 0/ffffffff", zero, result); end
        drive(1'b0, 4'd0, 32'd0, 32'd0);
        @(negedge clk);
    endtask

    task automatic test_mul(input logic [31:0] a, input logic [31:0] b, input int lat, input logic [31:0] exp);
        drive(1'b1, 4'd5, a, b);
        #1;
        n_checks++; if (stall !== 1'b1) begin n_fail++; $display("FAIL mul_accept_stall got=%b exp=1", stall); end
        @(negedge clk);
        drive(1'b0, 4'd0, 32'd0, 32'd0);
        for (int k = 1; k < lat; k++) begin
            if (k == 5) drive(1'b1, 4'd3, 32'd1, 32'd1);
            if (k == 6) drive(1'b0, 4'd0, 32'd0, 32'd0);
            #1;
            n_checks++; if (stall !== 1'b1 || ready !== 1'b0 || done !== 1'b0) begin n_fail++; $display("FAIL mul_run[N+%0d] stall=%b ready=%b done=%b exp 1/0/0", k, stall, ready, done); end
            @(negedge clk);
        end
        n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL mul_done[N+%0d] got=%b exp=1", lat, done); end
        n_checks++; if (result !== exp) begin n_fail++; $display("FAIL mul_result got=%h exp=%h", result, exp); end
        n_checks++; if (zero !== (exp == 32'd0)) begin n_fail++; $display("FAIL mul_zero got=%b exp=%b", zero, (exp == 32'd0)); end
        n_checks++; if (stall !== 1'b0 || ready !== 1'b1) begin n_fail++; $display("FAIL mul_release stall=%b ready=%b exp 0/1", stall, ready); end
        @(negedge clk);
        n_checks++; if (done !== 1'b0 || result !== exp) begin n_fail++; $display("FAIL mul_after done=%b result=%h exp 0/%h", done, result, exp); end
    endtask

    task automatic test_flush;
        bit seen_done = 1'b0;
        drive(1'b1, 4'd3, 32'd3, 32'd4);
        @(negedge clk);
        n_checks++; if (result !== 32'd7) begin n_fail++; $display("FAIL flush_pre_add got=%h exp=7", result); end
        drive(1'b1, 4'd5, 32'd6, 32'd7);
        @(negedge clk);
        drive(1'b0, 4'd0, 32'd0, 32'd0);
        repeat (FLUSH_AT - 1) @(negedge clk);
        flush = 1'b1;
        #1;
        n_checks++; if (stall !== 1'b1) begin n_fail++; $display("FAIL flush_cycle_stall got=%b exp=1", stall); end
        @(negedge clk);
        flush = 1'b0;
        n_checks++; if (ready !== 1'b1 || stall !== 1'b0) begin n_fail++; $display("FAIL flush_idle ready=%b stall=%b exp 1/0", ready, stall); end
        n_checks++; if (result !== 32'd7 || done !== 1'b0) begin n_fail++; $display("FAIL flush_keep result=%h done=%b exp 7/0", result, done); end
        for (int k = 0; k < 40; k++) begin
            if (done === 1'b1) seen_done = 1'b1;
            @(negedge clk);
        end
        n_checks++; if (seen_done !== 1'b0 || result !== 32'd7) begin n_fail++; $display("FAIL flush_no_done seen=%b result=%h exp 0/7", seen_done, result); end
        drive(1'b1, 4'd3, 32'd1, 32'd1);
        @(negedge clk);
        n_checks++; if (done !== 1'b1 || result !== 32'd2) begin n_fail++; $display("FAIL flush_then_add done=%b result=%h exp 1/2", done, result); end
        drive(1'b1, 4'd3, 32'd5, 32'd5);
        flush = 1'b1;
        @(negedge clk);
        n_checks++; if (done !== 1'b0 || result !== 32'd2) begin n_fail++; $display("FAIL idle_flush_add done=%b result=%h exp 0/2", done, result); end
        drive(1'b1, 4'd5, 32'd2, 32'd2);
        #1;
        n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL idle_flush_mul_stall got=%b exp=0", stall); end
        @(negedge clk);
        flush = 1'b0;
        drive(1'b0, 4'd0, 32'd0, 32'd0);
        n_checks++; if (ready !== 1'b1 || done !== 1'b0) begin n_fail++; $display("FAIL idle_flush_mul ready=%b done=%b exp 1/0", ready, done); end
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0;
        drive(1'b0, 4'd0, 32'd0, 32'd0);
        @(negedge clk);
        test_reset();
        test_back_to_back();
        test_beq();
`ifdef MUL_EARLY_EXIT_EN
        test_mul(32'd9, 32'd5, 4, 32'd45);
        test_mul(32'd9, 32'd0, 2, 32'd0);
        test_mul(32'hFFFF_FFFF, 32'd3, 3, 32'hFFFF_FFFD);
`else
        test_mul(32'hFFFF_FFFF, 32'd3, 33, 32'hFFFF_FFFD);
        test_mul(32'd9, 32'd5, 33, 32'd45);
        test_mul(32'd9, 32'd0, 33, 32'd0);
`endif
        test_flush();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
